// File: rtl/print_buffer.sv
// print_buffer: text-mode word buffer fed by a processor port and a character stream,
// with a background clear engine and a registered display read port.
module print_buffer #(
    parameter int          DEPTH = 700,
    parameter int          AW    = 14,
    parameter int          COLS  = 40,
    parameter logic [31:0] FILL  = 32'h0000_0020
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [AW-1:0]            a,
    input  logic [31:0]              wd,
    input  logic [3:0]               be,
    input  logic                     char_valid,
    input  logic [7:0]               char_data,
    output logic                     char_ready,
    input  logic                     clr,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] cursor,
    output logic                     wrapped,
    output logic                     err,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [31:0]              rd_data
);
    localparam int CW = $clog2(DEPTH);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t        r_state;
    logic [31:0]   r_mem [DEPTH];
    logic [CW-1:0] r_clr_idx;
    logic [CW-1:0] r_cursor;
    logic          r_wrapped;
    logic          r_err;
    logic [31:0]   r_rd_data;

    logic [AW-3:0] w_pidx;
    logic          w_pin;
    logic          w_idle;
    logic          w_clear;
    logic          w_accept;
    logic          w_nl;
    logic          w_bs;
    logic          w_at0;
    int            w_adv;
    logic          w_mwe;
    logic [CW-1:0] w_midx;
    logic [31:0]   w_mdata;
    logic [3:0]    w_mbe;
    logic          w_unused;

    assign w_unused = ^a[1:0];
    assign w_pidx   = a[AW-1:2];
    assign w_pin    = 32'(w_pidx) < DEPTH;
    assign w_idle   = r_state == IDLE;
    assign w_clear  = r_state == CLEAR;
    assign w_accept = char_valid & char_ready;
    assign w_nl     = char_data == 8'h0A;
    assign w_bs     = char_data == 8'h08;
    assign w_at0    = r_cursor == '0;
    assign w_adv    = w_nl ? (32'(r_cursor) / COLS + 1) * COLS : 32'(r_cursor) + 1;

    // One shared write port: clear engine, then processor, then stream.
    assign w_mwe   = rst & (w_clear | (we & w_pin) | (w_accept & ~w_nl & ~(w_bs & w_at0)));
    assign w_midx  = w_clear ? r_clr_idx : we ? CW'(w_pidx) : w_bs ? r_cursor - CW'(1) : r_cursor;
    assign w_mdata = w_clear ? FILL : we ? wd : w_bs ? FILL : {24'h0, char_data};
    assign w_mbe   = (~w_clear & we) ? be : 4'hF;

    always_ff @(posedge clk) begin
        if (w_mwe)
            for (int i = 0; i < 4; i++)
                if (w_mbe[i]) r_mem[w_midx][8*i +: 8] <= w_mdata[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_clr_idx <= '0;
            r_cursor  <= '0;
            r_wrapped <= 1'b0;
            r_err     <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_err     <= w_idle & we & ~w_pin;
            r_rd_data <= (32'(rd_addr) < DEPTH) ? r_mem[rd_addr] : 32'h0;
            if (w_clear) begin
                r_clr_idx <= r_clr_idx + CW'(1);
                if (32'(r_clr_idx) == DEPTH - 1) begin
                    r_state   <= IDLE;
                    r_cursor  <= '0;
                    r_wrapped <= 1'b0;
                end
            end else begin
                if (clr) begin
                    r_state   <= CLEAR;
                    r_clr_idx <= '0;
                end
                if (w_accept) begin
                    if (w_bs) begin
                        if (!w_at0) r_cursor <= r_cursor - CW'(1);
                    end else if (w_adv >= DEPTH) begin
                        r_cursor  <= '0;
                        r_wrapped <= 1'b1;
                    end else begin
                        r_cursor <= CW'(w_adv);
                    end
                end
            end
        end
    end

    assign char_ready = rst & w_idle & ~we;
    assign busy       = w_clear;
    assign cursor     = r_cursor;
    assign wrapped    = r_wrapped;
    assign err        = r_err;
    assign rd_data    = r_rd_data;
endmodule

// File: doc/print_buffer.md
PRINT_BUFFER -- requirements
Module: print_buffer

Interface
REQ-001 Parameter DEPTH, default 700, number of 32-bit text words.
REQ-002 Parameter AW, default 14, byte-address width of a.
REQ-003 Parameter COLS, default 40, characters per text line, used by newline handling.
REQ-004 Parameter FILL, default 32'h0000_0020, word written by clear and by backspace.
REQ-005 clk  in  1  single clock; all state updates on posedge clk.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 we  in  1  processor word write strobe.
REQ-008 a  in  AW  processor byte address; word index = a[AW-1:2].
REQ-009 wd  in  32  processor write data.
REQ-010 be  in  4  byte enables for we writes; be[i] gates wd[8i+7:8i].
REQ-011 char_valid  in  1  stream character offered.
REQ-012 char_data  in  8  stream character.
REQ-013 char_ready  out  1  stream character accepted this cycle when char_valid=1.
REQ-014 clr  in  1  single-cycle request to start a buffer clear.
REQ-015 busy  out  1  clear in progress.
REQ-016 cursor  out  $clog2(DEPTH)  stream write position.
REQ-017 wrapped  out  1  sticky: cursor has wrapped at least once.
REQ-018 err  out  1  one-cycle pulse on an out-of-range we write.
REQ-019 rd_addr  in  $clog2(DEPTH)  display read word index.
REQ-020 rd_data  out  32  registered display read data.

Function
REQ-021 FSM states: IDLE, CLEAR; IDLE->CLEAR when clr=1 in IDLE; CLEAR->IDLE after writing index DEPTH-1.
REQ-022 CLEAR writes FILL to one index per cycle, 0 to DEPTH-1 ascending, taking exactly DEPTH cycles; busy=1 throughout.
REQ-023 On CLEAR exit, cursor=0 and wrapped=0; clr received during CLEAR is ignored.
REQ-024 char_ready = (state==IDLE) & ~we; we has priority over the stream in the same cycle.
REQ-025 In CLEAR, we writes are dropped with no err pulse.
REQ-026 we in IDLE with index < DEPTH writes enabled bytes of wd; bytes with be[i]=0 are unchanged.
REQ-027 we in IDLE with index >= DEPTH leaves memory unchanged and pulses err the next cycle.
REQ-028 Stream accept (char_valid & char_ready), ordinary character: memory[cursor] <= {24'h0, char_data}; cursor <= cursor+1.
REQ-029 Stream 8'h0A (newline): no memory write; cursor advances to the next multiple of COLS.
REQ-030 Stream 8'h08 (backspace): when cursor>0, cursor decrements and FILL is written at the new cursor; when cursor==0, no change.
REQ-031 Any cursor advance that reaches or passes DEPTH sets cursor=0 and sets wrapped=1.
REQ-032 rd_data <= memory[rd_addr] each cycle; latency is 1 cycle.
REQ-033 rd_data during a same-cycle write to rd_addr returns the old contents.
REQ-034 rd_addr >= DEPTH returns 32'h0.
REQ-035 Processor writes do not move the cursor.

Reset
REQ-036 While rst=0 at posedge clk: state=IDLE, cursor=0, wrapped=0, busy=0, err=0, rd_data=0.
REQ-037 Memory contents are not reset.
REQ-038 Reset during CLEAR aborts the clear; words not yet cleared keep prior contents.
REQ-039 char_ready stays 0 while rst=0.

Verification
REQ-040 Write we=1, a=0x008, wd=0x00000041, be=4'hF; then rd_addr=2 -> rd_data=0x00000041 one cycle later.
REQ-041 Write word 2 with be=4'b0010, wd=0x0000FF00 over 0x00000041 -> word 2 reads 0x0000FF41.
REQ-042 Stream "H","i",0x0A from cursor=0 -> words 0,1 hold 0x48 and 0x69; cursor=40.
REQ-043 Apply char_valid and we together -> char_ready=0; only the we write lands; cursor unchanged.
REQ-044 Set cursor to 699 and stream one char -> word 699 is written, cursor=0, wrapped=1.
REQ-045 Pulse clr -> busy=1 for 700 cycles; all words read 0x00000020; cursor=0, wrapped=0. Repeat with rst=0 at cycle 100 -> busy drops; word 150 keeps its old value.
